// File: rtl/audio_pkg.sv
// Shared definitions for the audio post-processing path.
package audio_pkg;

    localparam int AUDIO_W    = 24;
    localparam int MAX_LOG2_N = 5;

    typedef logic signed [AUDIO_W-1:0] sample_t;

    // Output-register occupancy of the moving-average stage.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ma_state_t;

endpackage

// File: rtl/moving_average_channel.sv
// One channel of the boxcar filter: circular history, running sum, and the
// registered mean. The write pointer and handshake live in the parent.
module moving_average_channel
    import audio_pkg::*;
#(
    parameter int WIDTH  = AUDIO_W,
    parameter int LOG2_N = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     acc,
    input  logic [LOG2_N-1:0]        ptr,
    input  logic signed [WIDTH-1:0]  x,
    output logic signed [WIDTH-1:0]  mean
);

    localparam int N  = 1 << LOG2_N;
    localparam int SW = WIDTH + LOG2_N;

    logic signed [WIDTH-1:0] hist [N];
    logic signed [SW-1:0]    sum;
    logic signed [SW-1:0]    sum_next;
    logic signed [SW-1:0]    x_ext;
    logic signed [SW-1:0]    old_ext;
    logic signed [SW-1:0]    shifted;

    // Sum of the last N samples; the oldest (at ptr) is swapped for the new one.
    // |sum| <= N*2^(WIDTH-1), so SW bits never overflow and the mean needs no
    // saturation.
    always_comb begin
        x_ext    = {{LOG2_N{x[WIDTH-1]}}, x};
        old_ext  = {{LOG2_N{hist[ptr][WIDTH-1]}}, hist[ptr]};
        sum_next = sum + x_ext - old_ext;
        shifted  = sum_next >>> LOG2_N;
    end

    // History, running sum and mean register; flush wipes history but lets the
    // (now invalid) mean register hold its last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                hist[i] <= '0;
            end
            sum  <= '0;
            mean <= '0;
        end else if (flush) begin
            for (int i = 0; i < N; i++) begin
                hist[i] <= '0;
            end
            sum <= '0;
        end else if (acc) begin
            hist[ptr] <= x;
            sum       <= sum_next;
            mean      <= shifted[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/audio_moving_average.sv
// Stereo N-tap boxcar low-pass between the distortion effects and the codec
// write port. One pair in per handshake, one registered averaged pair out.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_EMPTY | output register holds no pending pair, out_valid = 0
// ST_FULL  | output pair pending for the codec, out_valid = 1
module audio_moving_average
    import audio_pkg::*;
#(
    parameter int WIDTH  = AUDIO_W,
    parameter int LOG2_N = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [WIDTH-1:0]  data_left_in,
    input  logic signed [WIDTH-1:0]  data_right_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [WIDTH-1:0]  data_left_out,
    output logic signed [WIDTH-1:0]  data_right_out
);

    ma_state_t         state;
    logic [LOG2_N-1:0] ptr;
    logic              acc;

    // A new pair may enter whenever the output slot is free or being drained;
    // flush deliberately does not gate in_ready, it only drops the pair.
    always_comb begin
        in_ready = ~out_valid | out_ready;
        acc      = in_valid & in_ready & ~flush;
    end

    // Output-slot FSM with registered out_valid and the shared write pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else begin
            if (acc) begin
                ptr <= ptr + LOG2_N'(1);
            end
            case (state)
                ST_EMPTY: begin
                    if (acc) begin
                        state     <= ST_FULL;
                        out_valid <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (!acc && out_ready) begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    moving_average_channel #(
        .WIDTH  (WIDTH),
        .LOG2_N (LOG2_N)
    ) u_left (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .acc     (acc),
        .ptr     (ptr),
        .x       (data_left_in),
        .mean    (data_left_out)
    );

    moving_average_channel #(
        .WIDTH  (WIDTH),
        .LOG2_N (LOG2_N)
    ) u_right (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .acc     (acc),
        .ptr     (ptr),
        .x       (data_right_in),
        .mean    (data_right_out)
    );

endmodule

// File: tb/tb_audio_moving_average.sv
// Directed bench for audio_moving_average with LOG2_N = 3 (8 taps).
module tb_audio_moving_average;

    logic               clk;
    logic               reset_n;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic signed [23:0] data_left_in;
    logic signed [23:0] data_right_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [23:0] data_left_out;
    logic signed [23:0] data_right_out;

    int n_cmp;
    int n_fail;

    audio_moving_average #(
        .WIDTH  (24),
        .LOG2_N (3)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .data_left_in   (data_left_in),
        .data_right_in  (data_right_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .data_left_out  (data_left_out),
        .data_right_out (data_right_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, clock it in, sample 1 time unit later.
    task automatic cyc(input logic v, input int l, input int r, input logic ordy);
        in_valid      = v;
        data_left_in  = 24'(l);
        data_right_in = 24'(r);
        out_ready     = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        n_cmp++;
        if (out_valid !== 1'b0 || data_left_out !== 24'sd0 || data_right_out !== 24'sd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b l=%0d r=%0d want v=0 l=0 r=0",
                     out_valid, data_left_out, data_right_out);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_impulse();
        int exp_l;
        do_flush();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, (i == 0) ? 800000 : 0, 0, 1'b1);
            exp_l = (i < 8) ? 100000 : 0;
            n_cmp++;
            if (out_valid !== 1'b1 || data_left_out !== exp_l || data_right_out !== 24'sd0) begin
                n_fail++;
                $display("FAIL impulse[%0d]: got v=%b l=%0d r=%0d want v=1 l=%0d r=0",
                         i, out_valid, data_left_out, data_right_out, exp_l);
            end
        end
        cyc(1'b0, 0, 0, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL impulse_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_ramp();
        int exp_l, exp_r;
        do_flush();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, -8, 8, 1'b1);
            exp_l = (i < 8) ? -(i + 1) : -8;
            exp_r = (i < 8) ? (i + 1) : 8;
            n_cmp++;
            if (data_left_out !== exp_l || data_right_out !== exp_r) begin
                n_fail++;
                $display("FAIL ramp[%0d]: got l=%0d r=%0d want l=%0d r=%0d",
                         i, data_left_out, data_right_out, exp_l, exp_r);
            end
        end
        do_flush();
        cyc(1'b1, -1, 1, 1'b1);
        n_cmp++;
        if (data_left_out !== -24'sd1 || data_right_out !== 24'sd0) begin
            n_fail++;
            $display("FAIL floor_round: got l=%0d r=%0d want l=-1 r=0",
                     data_left_out, data_right_out);
        end
    endtask

    task automatic test_extremes();
        do_flush();
        cyc(1'b1, 8388607, -8388608, 1'b1);
        n_cmp++;
        if (data_left_out !== 24'sd1048575 || data_right_out !== -24'sd1048576) begin
            n_fail++;
            $display("FAIL extreme_first: got l=%0d r=%0d want l=1048575 r=-1048576",
                     data_left_out, data_right_out);
        end
        for (int i = 1; i < 9; i++) begin
            cyc(1'b1, 8388607, -8388608, 1'b1);
        end
        n_cmp++;
        if (data_left_out !== 24'sd8388607 || data_right_out !== -24'sd8388608) begin
            n_fail++;
            $display("FAIL extreme_settle: got l=%0d r=%0d want l=8388607 r=-8388608",
                     data_left_out, data_right_out);
        end
    endtask

    task automatic test_backpressure();
        // Cumulative sums of 80*k over 8 taps: means 10,30,60,100,150,210,280.
        int exp_l [7] = '{10, 30, 60, 100, 150, 210, 280};
        do_flush();
        cyc(1'b1, 80, -80, 1'b0);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                data_left_out !== 24'sd10 || data_right_out !== -24'sd10) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got rdy=%b v=%b l=%0d r=%0d want rdy=0 v=1 l=10 r=-10",
                         i, in_ready, out_valid, data_left_out, data_right_out);
            end
            // The next pair is offered but must not be taken while stalled.
            cyc(1'b1, 160, -160, 1'b0);
        end
        for (int k = 1; k < 7; k++) begin
            cyc(1'b1, 80 * (k + 1), -80 * (k + 1), 1'b1);
            n_cmp++;
            if (out_valid !== 1'b1 || data_left_out !== exp_l[k] || data_right_out !== -exp_l[k]) begin
                n_fail++;
                $display("FAIL bp_flow[%0d]: got v=%b l=%0d r=%0d want v=1 l=%0d r=%0d",
                         k, out_valid, data_left_out, data_right_out, exp_l[k], -exp_l[k]);
            end
        end
        cyc(1'b0, 0, 0, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        do_flush();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 400000, 400000, 1'b1);
        end
        n_cmp++;
        if (data_left_out !== 24'sd200000) begin
            n_fail++;
            $display("FAIL flush_pre: got l=%0d want 200000", data_left_out);
        end
        flush = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_in_ready: got %b want 1", in_ready);
        end
        cyc(1'b1, 123456, 123456, 1'b1);
        flush = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_valid: got out_valid=%b want 0", out_valid);
        end
        cyc(1'b1, 800000, -800000, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b1 || data_left_out !== 24'sd100000 || data_right_out !== -24'sd100000) begin
            n_fail++;
            $display("FAIL flush_after: got v=%b l=%0d r=%0d want v=1 l=100000 r=-100000",
                     out_valid, data_left_out, data_right_out);
        end
    endtask

    task automatic test_async_reset();
        do_flush();
        cyc(1'b1, 4000, 4000, 1'b1);
        cyc(1'b1, 4000, 4000, 1'b0);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || data_left_out !== 24'sd0 || data_right_out !== 24'sd0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b l=%0d r=%0d want v=0 l=0 r=0",
                     out_valid, data_left_out, data_right_out);
        end
        #1;
        reset_n = 1'b1;
        cyc(1'b1, 80, -80, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b1 || data_left_out !== 24'sd10 || data_right_out !== -24'sd10) begin
            n_fail++;
            $display("FAIL post_reset: got v=%b l=%0d r=%0d want v=1 l=10 r=-10",
                     out_valid, data_left_out, data_right_out);
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        flush         = 1'b0;
        in_valid      = 1'b0;
        out_ready     = 1'b1;
        data_left_in  = '0;
        data_right_in = '0;
        test_reset();
        test_impulse();
        test_ramp();
        test_extremes();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_moving_average.md
# audio_moving_average

Stereo N-tap boxcar (moving-average) low-pass stage placed directly downstream of the distortion effects and upstream of the codec write port. Distortion clipping adds harsh high-frequency content, and this stage smooths it. The block accepts one left/right sample pair per valid/ready handshake and keeps an N-deep circular history per channel. It emits the running mean through a single registered output stage that connects to the codec `write`/`write_ready` pair.

## Interface
- `WIDTH`, default 24: sample width, signed two's complement.
- `LOG2_N`, default 3: log2 of the tap count. N = 2^LOG2_N; legal range 1..5.
- `clk`  in  1: system clock; all state is updated on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `flush`  in  1: synchronous clear of history, sum and pointer.
- `in_valid`  in  1: an input sample pair is present.
- `in_ready`  out  1: the block can accept a pair this cycle.
- `data_left_in`, `data_right_in`  in  WIDTH each: signed input samples.
- `out_valid`  out  1: the output pair is valid; drives codec `write`.
- `out_ready`  in  1: downstream accepts the pair; driven by codec `write_ready`.
- `data_left_out`, `data_right_out`  out  WIDTH each: signed averaged samples.

## Operation
- **Per-channel state**
  - History array `hist[0..N-1]` of WIDTH bits each.
  - Running sum of WIDTH+LOG2_N bits.
  - One write pointer `ptr` of LOG2_N bits, shared by both channels.
- **Accept condition:** `acc = in_valid & in_ready & ~flush`.
- **On `acc`, for each channel:**
  - `sum_next = sum + sext(x) - sext(hist[ptr])`
  - `hist[ptr] <= x`
  - `ptr <= ptr + 1`, wrapping modulo N.
  - Output register loads `sum_next >>> LOG2_N` (arithmetic shift, floor toward −∞).
  - `out_valid <= 1`.
- **Warm-up:** history starts at zero, so the first N-1 outputs ramp toward the true mean. No fill counter is used and no output is suppressed.
- **Width rule:** the sum cannot overflow, because |sum| ≤ N·2^(WIDTH-1). The shifted result always fits in WIDTH bits and no saturation is needed.
- **Output handshake:**
  - `in_ready = ~out_valid | out_ready` (combinational pass-through of `out_ready`).
  - If `out_valid & out_ready & ~acc`, then `out_valid <= 0`.
  - Output data holds stable while `out_valid & ~out_ready`.
- **`flush`:**
  - Zeroes all history, both sums and `ptr`, and clears `out_valid`.
  - Has priority over `acc` and over a pending output; the input on that cycle is dropped.
  - `in_ready` is not gated by `flush`.
- **Two-state control:**
  - EMPTY (`out_valid = 0`) moves to FULL on `acc`.
  - FULL moves to EMPTY on `out_ready & ~acc`, or on `flush`.
  - FULL stays FULL on `acc` with `out_ready` (back-to-back throughput of one pair per cycle).
- Left and right channels are fully independent apart from the shared pointer and handshake.

## Timing
- **Reset values (asynchronous):**
  - `out_valid = 0`, `data_left_out = 0`, `data_right_out = 0`.
  - Sums, `hist` and `ptr` all 0.
  - `in_ready = 1`.
- **Latency:** 1 cycle from the accepting edge to `out_valid` high with data.
- **Throughput:** one pair per cycle while `out_ready` is held high.
- **Reset mid-stream:** a pending output is discarded and history is lost. The first post-reset sample behaves as warm-up sample 1.
- **Pointer wrap:** `ptr` goes from N-1 to 0 with no bubble.
- **Flush and accept on the same cycle:** flush wins.

## Structure
- Shared package `audio_pkg`:
  - `AUDIO_W = 24`.
  - `typedef logic signed [AUDIO_W-1:0] sample_t`.
- Sub-module `moving_average_channel` holds the history, sum and mean for one channel; the top module instantiates it twice.
- The top module holds `ptr`, `out_valid` and the handshake logic.

## Test plan
All scenarios use `LOG2_N = 3`.
- **Impulse:** 800000 followed by 9 zeros, with `out_ready = 1` → left output 100000 for 8 samples, then 0, 0. Right channel is driven 0 throughout → right output stays 0.
- **Constant ramp:** −8 held for 10 samples → outputs −1, −2, …, −8, −8, −8. Also check floor rounding: a single −1 gives −1.
- **Extremes:** 8388607 ×8 → settles at 8388607. −8388608 ×8 → settles at −8388608. No wrap occurs.
- **Backpressure:** hold `out_ready = 0` for 5 cycles while `in_valid = 1`.
  - `in_ready` is 0 after the first accept and output data stays stable.
  - Releasing `out_ready` resumes one-per-cycle flow with no lost or duplicated samples; compare against a reference model.
- **Flush:** feed 400000 ×4, then assert `flush` together with `in_valid` → `out_valid` is 0 the next cycle. The next sample, 800000, gives output 100000.
- **Async reset:** assert `reset_n = 0` mid-stream, between clock edges → outputs are 0 immediately. After release, the history is empty, so input 80 gives output 10.
